key_note_scheduler: RTL
=======================

Name: key_note_scheduler

Overview:
- Sits between the PS/2 keyboard receiver and both consumers: the piano drawer and the shared tone generator.
- Decodes the PS/2 set-2 byte stream (make, F0 break and E0 extended prefixes) into a 12-key pressed mask.
- Arbitrates the single tone generator among held keys. The most recently pressed key wins; on its release, ownership falls back to the lowest-index held key.
- Presents the mask to the drawer only at frame start, so a key never changes colour mid-frame.

Parameters:
- TIMEOUT_CYCLES, 50000000: idle cycles with no received byte before all keys are force-released (stuck-key guard, 1 s at 50 MHz).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- iByte  in  8  received PS/2 byte.
- iByteValid  in  1  one-cycle strobe; iByte is valid this cycle.
- iFrameStart  in  1  one-cycle strobe at the start of each VGA frame.
- oKeyMask  out  12  frame-latched pressed mask; bit0=C … bit11=B.
- oNoteValid  out  1  tone generator has an owner.
- oNoteIndex  out  4  owning key, 0..11.
- oNoteChange  out  1  one-cycle pulse when oNoteValid or oNoteIndex changes.

Behaviour:
- Reset values: every output is 0. Internal mask, owner, decoder state and timeout counter are also 0 / IDLE. Reset mid-sequence discards any pending F0/E0 prefix.
- Key map (set-2 make codes, index order C..B): 1C, 1D, 1B, 24, 23, 2B, 2C, 34, 35, 33, 3C, 3B.
- Decoder FSM, advancing only on cycles with iByteValid=1:
  - IDLE: F0→BREAK; E0→EXT; mapped code→make event; any other byte→stay IDLE.
  - BREAK: mapped code→break event; any byte→IDLE.
  - EXT: F0→EXT_BREAK; any other byte→IDLE, no event.
  - EXT_BREAK: any byte→IDLE, no event. Extended keys never affect the mask.
- Make event, key k:
  - Mask bit k is set.
  - If k was not already set, k becomes owner.
  - A typematic repeat of a held key changes neither the owner nor oNoteChange.
- Break event, key k:
  - Mask bit k is cleared. A break of an unheld key is a no-op.
  - If k was the owner, the new owner is the lowest index set in the updated mask. If the mask is now empty, oNoteValid=0 and oNoteIndex keeps its last value.
- Latency: the byte accepted at edge N updates the internal mask, oNoteValid and oNoteIndex at edge N. They are visible in cycle N+1. oNoteChange is high for exactly cycle N+1.
- oKeyMask:
  - Loads the internal mask on the edge where iFrameStart=1.
  - If iFrameStart and iByteValid coincide, oKeyMask loads the pre-update mask. The new key appears at the next frame.
- Timeout counter, 32 bits:
  - Clears on every iByteValid and otherwise increments.
  - Saturates at TIMEOUT_CYCLES.
  - On the edge it reaches TIMEOUT_CYCLES while the mask is non-zero: clear the mask, set oNoteValid=0, pulse oNoteChange if oNoteValid was 1, and return the decoder to IDLE.
  - A byte arriving on that same edge takes priority: the counter clears and no timeout fires.
- No output is combinational from inputs; all outputs are registered.

Test Plan:
- Reset, then bytes 1C → next cycle: oNoteValid=1, oNoteIndex=0, oNoteChange pulse, oKeyMask=000 until the first iFrameStart, then 001.
- 1C, 24, F0 24 → owner 0, then 3, then back to 0 (lowest held); three oNoteChange pulses; internal mask goes 001, 009, 001.
- 1C, 24, F0 1C → owner stays 3, no oNoteChange on the break; mask 008. Then F0 24 → oNoteValid=0, one pulse, mask 000.
- 1C repeated 5× → one oNoteChange only; E0 1C and E0 F0 1C → no change; unmapped 15 → no change; break 2B while unheld → no change.
- Hold 3B, then TIMEOUT_CYCLES=100 with no bytes → on cycle 101 after the last byte: oNoteValid=0, pulse, mask 000. A byte at cycle 99 restarts the count and no timeout fires.
- iFrameStart on the same edge as 1C from empty → oKeyMask=000 that frame, 001 at the next iFrameStart. F0 then Reset then 1C → treated as a make (owner 0).

Source files
------------

// File: rtl/key_note_scheduler.sv
// PS/2 set-2 decoder feeding a 12-key pressed mask, tone-generator ownership
// arbitration (newest press wins, fallback to lowest held) and a frame-latched mask.
module key_note_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  iByte,
  input  logic        iByteValid,
  input  logic        iFrameStart,
  output logic [11:0] oKeyMask,
  output logic        oNoteValid,
  output logic [3:0]  oNoteIndex,
  output logic        oNoteChange
);

  localparam int unsigned KEYS  = 12;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} dec_state_e;

  dec_state_e       state_q, state_d;
  logic [KEYS-1:0]  mask_q, mask_d;
  logic [KEYS-1:0]  key_mask_q, key_mask_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             change_q, change_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0]       lookup;
  logic             hit;
  logic [IDX_W-1:0] key;
  logic [KEYS-1:0]  upd_mask;

  // Set-2 make code to key index, returned as {hit, index}.
  function automatic logic [4:0] map_code(input logic [7:0] code);
    case (code)
      8'h1C:   map_code = {1'b1, 4'd0};
      8'h1D:   map_code = {1'b1, 4'd1};
      8'h1B:   map_code = {1'b1, 4'd2};
      8'h24:   map_code = {1'b1, 4'd3};
      8'h23:   map_code = {1'b1, 4'd4};
      8'h2B:   map_code = {1'b1, 4'd5};
      8'h2C:   map_code = {1'b1, 4'd6};
      8'h34:   map_code = {1'b1, 4'd7};
      8'h35:   map_code = {1'b1, 4'd8};
      8'h33:   map_code = {1'b1, 4'd9};
      8'h3C:   map_code = {1'b1, 4'd10};
      8'h3B:   map_code = {1'b1, 4'd11};
      default: map_code = {1'b0, 4'd0};
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [KEYS-1:0] m);
    lowest_set = '0;
    for (int i = int'(KEYS) - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    key_mask_d = key_mask_q;
    valid_d    = valid_q;
    index_d    = index_q;
    cnt_d      = cnt_q;
    upd_mask   = mask_q;
    lookup     = map_code(iByte);
    hit        = lookup[4];
    key        = lookup[3:0];

    // Frame latch always sees the mask from before this cycle's byte.
    if (iFrameStart) key_mask_d = mask_q;

    if (iByteValid) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (iByte == 8'hF0) begin
            state_d = BREAK;
          end else if (iByte == 8'hE0) begin
            state_d = EXT;
          end else if (hit) begin
            mask_d[key] = 1'b1;
            if (!mask_q[key]) begin
              index_d = key;
              valid_d = 1'b1;
            end
          end
        end
        BREAK: begin
          state_d = IDLE;
          if (hit) begin
            upd_mask[key] = 1'b0;
            mask_d        = upd_mask;
            if (mask_q[key] && valid_q && index_q == key) begin
              if (upd_mask != '0) index_d = lowest_set(upd_mask);
              else                valid_d = 1'b0;
            end
          end
        end
        EXT:       state_d = (iByte == 8'hF0) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end else if (cnt_q != TMO) begin
      cnt_d = cnt_q + CNT_W'(1);
      // Stuck-key guard: drop everything when the idle count first hits the limit.
      if (cnt_d == TMO && mask_q != '0) begin
        mask_d  = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    end

    change_d = (valid_d != valid_q) || (index_d != index_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      key_mask_q <= '0;
      valid_q    <= 1'b0;
      index_q    <= '0;
      change_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      key_mask_q <= key_mask_d;
      valid_q    <= valid_d;
      index_q    <= index_d;
      change_q   <= change_d;
      cnt_q      <= cnt_d;
    end
  end

  assign oKeyMask    = key_mask_q;
  assign oNoteValid  = valid_q;
  assign oNoteIndex  = index_q;
  assign oNoteChange = change_q;

endmodule
